// File: rtl/decode_stage.sv
// Instruction decode stage: splits the word into fields, extends the immediate
// by mode, and buffers bundles in an output register plus a skid register.
module decode_stage #(
  parameter int OP_W   = 6,
  parameter int REG_W  = 2,
  parameter int IMM_W  = 12,
  parameter int DATA_W = 24,
  parameter int CNT_W  = 16,
  parameter int INSTR_W = OP_W + 3*REG_W + IMM_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    op,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic [REG_W-1:0]   rd,
  output logic [DATA_W-1:0]  imm,
  output logic [1:0]         imm_mode,
  output logic [CNT_W-1:0]   retired
);

  localparam int LONG_W = IMM_W + 3*REG_W;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
    logic [1:0]        mode;
  } bundle_t;

  bundle_t           dec;
  bundle_t           out_q, out_d;
  bundle_t           skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              in_hs, out_hs;

  logic signed [IMM_W-1:0]  imm_field;
  logic signed [LONG_W-1:0] long_field;

  assign imm_field  = instr[IMM_W-1:0];
  assign long_field = instr[LONG_W-1:0];

  always_comb begin
    dec      = '0;
    dec.op   = instr[INSTR_W-1 -: OP_W];
    dec.rs1  = instr[INSTR_W-OP_W-1 -: REG_W];
    dec.rs2  = instr[INSTR_W-OP_W-REG_W-1 -: REG_W];
    dec.rd   = instr[IMM_W+REG_W-1 -: REG_W];
    dec.mode = dec.op[OP_W-1 -: 2];
    case (dec.mode)
      2'b00:   dec.imm = '0;
      2'b01:   dec.imm = DATA_W'(imm_field);
      2'b10:   dec.imm = DATA_W'($unsigned(imm_field));
      default: dec.imm = DATA_W'(long_field);
    endcase
  end

  // in_ready_q always mirrors !skid_valid_q, so an accepted word never meets a full skid.
  assign in_hs  = in_valid && in_ready_q;
  assign out_hs = out_valid_q && out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    retired_d    = retired_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_hs) begin
        retired_d = retired_q + CNT_W'(1);
        if (skid_valid_q) begin
          out_d        = skid_q;
          skid_valid_d = 1'b0;
        end else if (in_hs) begin
          out_d = dec;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (in_hs) begin
        if (!out_valid_q) begin
          out_d       = dec;
          out_valid_d = 1'b1;
        end else begin
          skid_d       = dec;
          skid_valid_d = 1'b1;
        end
      end
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      retired_q    <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      retired_q    <= retired_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign op        = out_q.op;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign imm       = out_q.imm;
  assign imm_mode  = out_q.mode;
  assign retired   = retired_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of decoded vectors plus hand-built
// sequences for backpressure, flush, counter wrap and asynchronous reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, out_ready;
  logic [23:0] instr;

  logic        in_ready, out_valid;
  logic [5:0]  op;
  logic [1:0]  rs1, rs2, rd, imm_mode;
  logic [23:0] imm;
  logic [15:0] retired;

  logic        in_ready4, out_valid4;
  logic [5:0]  op4;
  logic [1:0]  rs1_4, rs2_4, rd_4, imm_mode4;
  logic [23:0] imm4;
  logic [3:0]  retired4;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .instr(instr), .out_valid(out_valid),
    .out_ready(out_ready), .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .imm_mode(imm_mode), .retired(retired)
  );

  decode_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready4), .instr(instr), .out_valid(out_valid4),
    .out_ready(out_ready), .op(op4), .rs1(rs1_4), .rs2(rs2_4), .rd(rd_4),
    .imm(imm4), .imm_mode(imm_mode4), .retired(retired4)
  );

  typedef struct {
    logic [23:0] instr;
    logic [5:0]  op;
    logic [1:0]  rs1, rs2, rd;
    logic [23:0] imm;
    logic [1:0]  mode;
  } vec_t;

  vec_t tbl [8];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_bundle(input string tag, input int k);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".op"},   32'(op),       32'(tbl[k].op));
    chk({tag, ".rs1"},  32'(rs1),      32'(tbl[k].rs1));
    chk({tag, ".rs2"},  32'(rs2),      32'(tbl[k].rs2));
    chk({tag, ".rd"},   32'(rd),       32'(tbl[k].rd));
    chk({tag, ".imm"},  32'(imm),      32'(tbl[k].imm));
    chk({tag, ".mode"}, 32'(imm_mode), 32'(tbl[k].mode));
    $display("%s: instr=%06h op=%02h rs1=%0d rs2=%0d rd=%0d imm=%06h mode=%0d retired=%0d",
             tag, tbl[k].instr, op, rs1, rs2, rd, imm, imm_mode, retired);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{24'h5A3FFF, 6'h16, 2'd2, 2'd0, 2'd3, 24'hFFFFFF, 2'd1};
    tbl[1] = '{24'h823FFF, 6'h20, 2'd2, 2'd0, 2'd3, 24'h000FFF, 2'd2};
    tbl[2] = '{24'h023FFF, 6'h00, 2'd2, 2'd0, 2'd3, 24'h000000, 2'd0};
    tbl[3] = '{24'hC20000, 6'h30, 2'd2, 2'd0, 2'd0, 24'hFE0000, 2'd3};
    tbl[4] = '{24'hC5FFFF, 6'h31, 2'd1, 2'd3, 2'd3, 24'h01FFFF, 2'd3};
    tbl[5] = '{24'h4D5800, 6'h13, 2'd1, 2'd1, 2'd1, 24'hFFF800, 2'd1};
    tbl[6] = '{24'h9C07FF, 6'h27, 2'd0, 2'd0, 2'd0, 24'h0007FF, 2'd2};
    tbl[7] = '{24'h4007FF, 6'h10, 2'd0, 2'd0, 2'd0, 24'h0007FF, 2'd1};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    #7;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.retired",   32'(retired),   32'd0);
    chk("rst.imm",       32'(imm),       32'd0);
    chk("rst.retired4",  32'(retired4),  32'd0);
    step; step;

    // Back-to-back stream, one decode per cycle; first word offered with reset release.
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr = tbl[i].instr; in_valid = 1'b1; out_ready = 1'b1;
      step;
      chk_bundle($sformatf("vec%0d", i), i);
    end
    in_valid = 1'b0;
    step;
    chk("stream.out_valid", 32'(out_valid), 32'd0);
    chk("stream.retired",   32'(retired),   32'd8);

    // Backpressure: two fill the buffer, third waits until out_ready rises.
    out_ready = 1'b0; in_valid = 1'b1; instr = tbl[0].instr;
    step;
    chk("bp.in_ready1", 32'(in_ready), 32'd1);
    instr = tbl[1].instr;
    step;
    chk("bp.in_ready2", 32'(in_ready), 32'd0);
    instr = tbl[2].instr;
    step;
    chk_bundle("bp.hold", 0);
    chk("bp.in_ready3", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step;
    chk_bundle("bp.out1", 1);
    step;
    chk_bundle("bp.out2", 2);
    in_valid = 1'b0;
    step;
    chk("bp.out_valid", 32'(out_valid), 32'd0);
    chk("bp.retired",   32'(retired),   32'd11);

    // Flush with both entries full and a same-cycle input.
    out_ready = 1'b0; in_valid = 1'b1; instr = tbl[0].instr;
    step;
    instr = tbl[1].instr;
    step;
    chk("fl.full", 32'(in_ready), 32'd0);
    flush = 1'b1; out_ready = 1'b1; instr = tbl[3].instr;
    step;
    chk("fl.out_valid", 32'(out_valid), 32'd0);
    chk("fl.in_ready",  32'(in_ready),  32'd1);
    chk("fl.retired",   32'(retired),   32'd11);
    flush = 1'b0; in_valid = 1'b0;
    step;
    chk("fl.no_ghost", 32'(out_valid), 32'd0);
    in_valid = 1'b1; instr = tbl[4].instr;
    step;
    chk_bundle("fl.next", 4);
    in_valid = 1'b0;
    step;
    chk("fl.retired2", 32'(retired), 32'd12);

    // Asynchronous reset between edges with both entries occupied.
    out_ready = 1'b0; in_valid = 1'b1; instr = tbl[6].instr;
    step;
    instr = tbl[7].instr;
    step;
    #3 reset_n = 1'b0;
    #1;
    chk("ar.out_valid", 32'(out_valid), 32'd0);
    chk("ar.in_ready",  32'(in_ready),  32'd1);
    chk("ar.retired",   32'(retired),   32'd0);
    chk("ar.op",        32'(op),        32'd0);
    chk("ar.imm",       32'(imm),       32'd0);
    chk("ar.mode",      32'(imm_mode),  32'd0);
    reset_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1; instr = tbl[5].instr;
    step;
    chk_bundle("ar.first", 5);
    in_valid = 1'b0;
    step;
    chk("ar.drained", 32'(out_valid), 32'd0);
    chk("ar.retired1", 32'(retired), 32'd1);

    // Sixteen more handshakes: 17 since reset, so the 4-bit counter wraps to 1.
    for (int i = 0; i < 16; i++) begin
      instr = tbl[i % 8].instr; in_valid = 1'b1;
      step;
    end
    in_valid = 1'b0;
    step;
    chk("wrap.retired16", 32'(retired),  32'd17);
    chk("wrap.retired4",  32'(retired4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
